mem_ctrl: RTL and testbench

- Single owner of the byte-wide RAM/IO port.
- Arbitrates three requesters:
  - instruction fetcher: 4-byte reads.
  - load/store buffer: 1/2/4-byte loads, signed or unsigned.
  - ROB: committed 1/2/4-byte stores.
- Serialises each access into byte cycles, assembles or splits little-endian words, returns a one-cycle done pulse to the owning requester.
- Honours branch-mispredict flush and IO-buffer backpressure.

---
 rtl/mem_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: single owner of the byte-wide RAM/IO port.
//
// It arbitrates three requesters (instruction fetcher, load/store buffer and
// ROB committed stores). Each access is split into byte cycles on the memory
// port. Read bytes are assembled into little-endian words, and store words
// are split into bytes. The owner of each access gets a one-cycle done pulse.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable; low freezes every register
//   io_buffer_full    IO output FIFO full; stalls writes into the IO window
//   mem_din           RAM read byte (reflects mem_a of the previous cycle)
//   mem_dout, mem_a, mem_wr   RAM write byte / byte address / write strobe
//   in_fetcher_*      fetch request (4-byte read)
//   out_fetcher_*     fetch done pulse and instruction word
//   in_lsb_*          load request (size 1/2/4, signed or unsigned)
//   out_lsb_*         load done pulse and extended value
//   in_rob_*          committed store request (size 1/2/4)
//   out_rob_flag      store done pulse
//   in_rob_xbp        mispredict flush (drops fetch/load work, keeps stores)
//
// Request handshake: each in_*_flag is a single-cycle pulse. The controller
// owns at most one outstanding request per requester. A pulse that arrives
// while that requester is already pending is ignored. Completion is
// signalled by exactly one cycle of the matching out_*_flag.
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h30000,
  parameter int unsigned IO_SPAN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        in_fetcher_flag,
  input  logic [31:0] in_fetcher_addr,
  output logic        out_fetcher_flag,
  output logic [31:0] out_fetcher_data,
  input  logic        in_lsb_flag,
  input  logic [5:0]  in_lsb_size,
  input  logic        in_lsb_signed,
  input  logic [31:0] in_lsb_addr,
  output logic        out_lsb_flag,
  output logic [31:0] out_lsb_data,
  input  logic        in_rob_flag,
  input  logic [5:0]  in_rob_size,
  input  logic [31:0] in_rob_addr,
  input  logic [31:0] in_rob_data,
  output logic        out_rob_flag,
  input  logic        in_rob_xbp
);

  localparam logic [31:0] IO_END = IO_BASE + IO_SPAN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state, state_next;

  // Byte count from the request size field; anything not 1 or 2 is a word.
  function automatic logic [2:0] size_to_n(input logic [5:0] size);
    case (size)
      6'd1:    return 3'd1;
      6'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic in_io(input logic [31:0] addr);
    return (addr >= IO_BASE) && (addr < IO_END);
  endfunction

  // Pending request latches
  logic        f_pend;
  logic [31:0] f_addr;
  logic        l_pend;
  logic [31:0] l_addr;
  logic [2:0]  l_n;
  logic        l_signed;
  logic        r_pend;
  logic [31:0] r_addr;
  logic [2:0]  r_n;
  logic [31:0] r_data;

  // Access currently on the port
  logic [31:0] op_addr;
  logic [2:0]  op_n;
  logic        op_signed;
  logic        op_is_lsb;
  logic [31:0] op_data;
  logic [2:0]  cnt;     // READ: edges since accept; WRITE: bytes issued
  logic [31:0] rd_buf;

  // Arbitration view
  logic        flush;
  logic        f_req, l_req, r_req;
  logic        read_done, can_accept;
  logic        grant_r, grant_l, grant_f;
  logic [31:0] f_addr_eff, l_addr_eff, r_addr_eff, r_data_eff;
  logic [2:0]  l_n_eff, r_n_eff;
  logic        l_signed_eff;

  // A request pulsed this cycle competes as if it were already latched.
  // A flush hides fetch and load work, both latched and freshly pulsed.
  always_comb begin
    flush        = in_rob_xbp;
    f_addr_eff   = f_pend ? f_addr   : in_fetcher_addr;
    l_addr_eff   = l_pend ? l_addr   : in_lsb_addr;
    l_n_eff      = l_pend ? l_n      : size_to_n(in_lsb_size);
    l_signed_eff = l_pend ? l_signed : in_lsb_signed;
    r_addr_eff   = r_pend ? r_addr   : in_rob_addr;
    r_n_eff      = r_pend ? r_n      : size_to_n(in_rob_size);
    r_data_eff   = r_pend ? r_data   : in_rob_data;

    f_req = !flush && (f_pend || in_fetcher_flag);
    l_req = !flush && (l_pend || in_lsb_flag);
    r_req = r_pend || in_rob_flag;

    read_done  = (state == READ) && (cnt == op_n);
    // A read may hand the port over on its completion edge.
    can_accept = (state == IDLE) || (read_done && !flush);

    grant_r = can_accept && r_req;
    grant_l = can_accept && !r_req && l_req;
    grant_f = can_accept && !r_req && !l_req && f_req;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_r)                 state_next = WRITE;
        else if (grant_l || grant_f) state_next = READ;
      end
      READ: begin
        if (flush) begin
          state_next = IDLE;
        end else if (read_done) begin
          if (grant_r)                 state_next = WRITE;
          else if (grant_l || grant_f) state_next = READ;
          else                         state_next = IDLE;
        end
      end
      WRITE: begin
        if (cnt == op_n) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values
  logic [31:0] mem_a_d;
  logic [7:0]  mem_dout_d;
  logic        mem_wr_d;
  logic        f_flag_d, l_flag_d, r_flag_d;
  logic [31:0] f_data_d, l_data_d;
  logic [2:0]  cnt_d;
  logic [31:0] rd_buf_d;

  logic [31:0] iss_base, iss_data, iss_addr, iss_shifted;
  logic [2:0]  iss_idx;
  logic        iss_stall;
  logic [3:0]  cnt_p1;
  logic [31:0] asm_word, ext_word;

  always_comb begin
    // Byte to put on the port: byte 0 of a freshly granted store,
    // otherwise the next byte of the store in progress.
    iss_base    = grant_r ? r_addr_eff : op_addr;
    iss_data    = grant_r ? r_data_eff : op_data;
    iss_idx     = grant_r ? 3'd0 : cnt;
    iss_addr    = iss_base + {29'd0, iss_idx};
    iss_shifted = iss_data >> {iss_idx, 3'b000};
    iss_stall   = in_io(iss_addr) && io_buffer_full;

    cnt_p1 = {1'b0, cnt} + 4'd1;

    // The last byte arrives on mem_din at the completion edge itself.
    case (op_n)
      3'd1:    asm_word = {rd_buf[31:8], mem_din};
      3'd2:    asm_word = {rd_buf[31:16], mem_din, rd_buf[7:0]};
      default: asm_word = {mem_din, rd_buf[23:0]};
    endcase

    case (op_n)
      3'd1:    ext_word = op_signed ? {{24{asm_word[7]}}, asm_word[7:0]}
                                    : {24'd0, asm_word[7:0]};
      3'd2:    ext_word = op_signed ? {{16{asm_word[15]}}, asm_word[15:0]}
                                    : {16'd0, asm_word[15:0]};
      default: ext_word = asm_word;
    endcase

    mem_a_d    = mem_a;
    mem_dout_d = mem_dout;
    mem_wr_d   = 1'b0;
    f_flag_d   = 1'b0;
    l_flag_d   = 1'b0;
    r_flag_d   = 1'b0;
    f_data_d   = out_fetcher_data;
    l_data_d   = out_lsb_data;
    cnt_d      = cnt;
    rd_buf_d   = rd_buf;

    case (state)
      READ: begin
        if (!flush) begin
          // Byte for address op_addr+k arrives two edges after it was addressed.
          case (cnt)
            3'd1:    rd_buf_d[7:0]   = mem_din;
            3'd2:    rd_buf_d[15:8]  = mem_din;
            3'd3:    rd_buf_d[23:16] = mem_din;
            default: ;
          endcase
          if (cnt_p1 < {1'b0, op_n}) mem_a_d = op_addr + {28'd0, cnt_p1};
          cnt_d = cnt_p1[2:0];
          if (read_done) begin
            if (op_is_lsb) begin
              l_flag_d = 1'b1;
              l_data_d = ext_word;
            end else begin
              f_flag_d = 1'b1;
              f_data_d = asm_word;
            end
          end
        end
      end
      WRITE: begin
        if (cnt == op_n) begin
          r_flag_d = 1'b1;
        end else if (!iss_stall) begin
          mem_wr_d   = 1'b1;
          mem_a_d    = iss_addr;
          mem_dout_d = iss_shifted[7:0];
          cnt_d      = cnt + 3'd1;
        end
      end
      default: ;
    endcase

    // Accepting a new access overrides the per-state updates above.
    if (grant_r) begin
      cnt_d = 3'd0;
      if (!iss_stall) begin
        mem_wr_d   = 1'b1;
        mem_a_d    = iss_addr;
        mem_dout_d = iss_shifted[7:0];
        cnt_d      = 3'd1;
      end
    end else if (grant_l || grant_f) begin
      cnt_d    = 3'd0;
      mem_a_d  = grant_l ? l_addr_eff : f_addr_eff;
      rd_buf_d = 32'd0;
    end
  end

  // Registers: outputs, counters, pending latches, current access
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_a            <= 32'd0;
      mem_dout         <= 8'd0;
      mem_wr           <= 1'b0;
      out_fetcher_flag <= 1'b0;
      out_fetcher_data <= 32'd0;
      out_lsb_flag     <= 1'b0;
      out_lsb_data     <= 32'd0;
      out_rob_flag     <= 1'b0;
      cnt              <= 3'd0;
      rd_buf           <= 32'd0;
      f_pend           <= 1'b0;
      f_addr           <= 32'd0;
      l_pend           <= 1'b0;
      l_addr           <= 32'd0;
      l_n              <= 3'd0;
      l_signed         <= 1'b0;
      r_pend           <= 1'b0;
      r_addr           <= 32'd0;
      r_n              <= 3'd0;
      r_data           <= 32'd0;
      op_addr          <= 32'd0;
      op_n             <= 3'd0;
      op_signed        <= 1'b0;
      op_is_lsb        <= 1'b0;
      op_data          <= 32'd0;
    end else if (rdy) begin
      mem_a            <= mem_a_d;
      mem_dout         <= mem_dout_d;
      mem_wr           <= mem_wr_d;
      out_fetcher_flag <= f_flag_d;
      out_fetcher_data <= f_data_d;
      out_lsb_flag     <= l_flag_d;
      out_lsb_data     <= l_data_d;
      out_rob_flag     <= r_flag_d;
      cnt              <= cnt_d;
      rd_buf           <= rd_buf_d;

      if (flush || grant_f) begin
        f_pend <= 1'b0;
      end else if (in_fetcher_flag && !f_pend) begin
        f_pend <= 1'b1;
        f_addr <= in_fetcher_addr;
      end

      if (flush || grant_l) begin
        l_pend <= 1'b0;
      end else if (in_lsb_flag && !l_pend) begin
        l_pend   <= 1'b1;
        l_addr   <= in_lsb_addr;
        l_n      <= size_to_n(in_lsb_size);
        l_signed <= in_lsb_signed;
      end

      if (grant_r) begin
        r_pend <= 1'b0;
      end else if (in_rob_flag && !r_pend) begin
        r_pend <= 1'b1;
        r_addr <= in_rob_addr;
        r_n    <= size_to_n(in_rob_size);
        r_data <= in_rob_data;
      end

      if (grant_r) begin
        op_addr   <= r_addr_eff;
        op_n      <= r_n_eff;
        op_data   <= r_data_eff;
        op_signed <= 1'b0;
        op_is_lsb <= 1'b0;
      end else if (grant_l) begin
        op_addr   <= l_addr_eff;
        op_n      <= l_n_eff;
        op_signed <= l_signed_eff;
        op_is_lsb <= 1'b1;
      end else if (grant_f) begin
        op_addr   <= f_addr_eff;
        op_n      <= 3'd4;
        op_signed <= 1'b0;
        op_is_lsb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl: fetches, signed/unsigned loads, stores
// with IO backpressure, arbitration, flush and mid-access reset.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, io_buffer_full;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        in_fetcher_flag;
  logic [31:0] in_fetcher_addr;
  logic        out_fetcher_flag;
  logic [31:0] out_fetcher_data;
  logic        in_lsb_flag;
  logic [5:0]  in_lsb_size;
  logic        in_lsb_signed;
  logic [31:0] in_lsb_addr;
  logic        out_lsb_flag;
  logic [31:0] out_lsb_data;
  logic        in_rob_flag;
  logic [5:0]  in_rob_size;
  logic [31:0] in_rob_addr;
  logic [31:0] in_rob_data;
  logic        out_rob_flag;
  logic        in_rob_xbp;

  int checks = 0;
  int passes = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .in_fetcher_flag(in_fetcher_flag), .in_fetcher_addr(in_fetcher_addr),
    .out_fetcher_flag(out_fetcher_flag), .out_fetcher_data(out_fetcher_data),
    .in_lsb_flag(in_lsb_flag), .in_lsb_size(in_lsb_size),
    .in_lsb_signed(in_lsb_signed), .in_lsb_addr(in_lsb_addr),
    .out_lsb_flag(out_lsb_flag), .out_lsb_data(out_lsb_data),
    .in_rob_flag(in_rob_flag), .in_rob_size(in_rob_size),
    .in_rob_addr(in_rob_addr), .in_rob_data(in_rob_data),
    .out_rob_flag(out_rob_flag), .in_rob_xbp(in_rob_xbp)
  );

  // Clock
  always #5 clk = ~clk;

  // RAM model: one-cycle read latency from the registered address
  logic [7:0] ram [int unsigned];
  always @(posedge clk) mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [31:0] addr);
    in_fetcher_flag = 1'b1;
    in_fetcher_addr = addr;
    tick();
    in_fetcher_flag = 1'b0;
    check_eq("fetch_accept_a", mem_a, addr);
  endtask

  task automatic start_load(input int size, input logic sgn, input logic [31:0] addr);
    in_lsb_flag   = 1'b1;
    in_lsb_size   = 6'(size);
    in_lsb_signed = sgn;
    in_lsb_addr   = addr;
    tick();
    in_lsb_flag = 1'b0;
    check_eq("load_accept_a", mem_a, addr);
  endtask

  // Follows a read from the cycle after its accept edge to one past its done pulse.
  task automatic run_read(input string tag, input logic is_lsb, input int n,
                          input logic [31:0] addr, input logic [31:0] exp);
    for (int k = 1; k <= n + 1; k++) begin
      tick();
      check_eq({tag, "_wr"}, mem_wr, 32'd0);
      if (k < n) check_eq({tag, "_a"}, mem_a, addr + 32'(k));
      if (is_lsb) check_eq({tag, "_flag"}, out_lsb_flag, (k == n + 1));
      else        check_eq({tag, "_flag"}, out_fetcher_flag, (k == n + 1));
    end
    if (is_lsb) check_eq({tag, "_data"}, out_lsb_data, exp);
    else        check_eq({tag, "_data"}, out_fetcher_data, exp);
    tick();
    if (is_lsb) check_eq({tag, "_flag_off"}, out_lsb_flag, 32'd0);
    else        check_eq({tag, "_flag_off"}, out_fetcher_flag, 32'd0);
  endtask

  task automatic set_store(input int size, input logic [31:0] addr, input logic [31:0] data);
    in_rob_flag = 1'b1;
    in_rob_size = 6'(size);
    in_rob_addr = addr;
    in_rob_data = data;
  endtask

  task automatic check_wbyte(input string tag, input logic [31:0] addr, input logic [7:0] data);
    check_eq({tag, "_wr"}, mem_wr, 32'd1);
    check_eq({tag, "_a"}, mem_a, addr);
    check_eq({tag, "_dout"}, mem_dout, {24'd0, data});
  endtask

  initial begin
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h10; ram[32'h1003] = 8'h00;
    ram[32'h0004] = 8'h93; ram[32'h0005] = 8'h00; ram[32'h0006] = 8'h10; ram[32'h0007] = 8'h00;
    ram[32'h2000] = 8'h80;
    ram[32'h2010] = 8'hFE; ram[32'h2011] = 8'hFF;
    ram[32'h2020] = 8'h11; ram[32'h2021] = 8'h22; ram[32'h2022] = 8'h33; ram[32'h2023] = 8'h44;

    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; in_rob_xbp = 1'b0;
    in_fetcher_flag = 1'b0; in_fetcher_addr = 32'd0;
    in_lsb_flag = 1'b0; in_lsb_size = 6'd0; in_lsb_signed = 1'b0; in_lsb_addr = 32'd0;
    in_rob_flag = 1'b0; in_rob_size = 6'd0; in_rob_addr = 32'd0; in_rob_data = 32'd0;

    // Reset state
    tick(); tick();
    check_eq("rst_wr", mem_wr, 32'd0);
    check_eq("rst_a", mem_a, 32'd0);
    check_eq("rst_flags", {out_fetcher_flag, out_lsb_flag, out_rob_flag}, 32'd0);
    check_eq("rst_fdata", out_fetcher_data, 32'd0);
    rst = 1'b0;
    tick();

    // Fetch: done 5 edges after accept
    start_fetch(32'h1000);
    run_read("fetch1", 1'b0, 4, 32'h1000, 32'h00100513);

    // Loads with extension
    start_load(1, 1'b1, 32'h2000);
    run_read("lb", 1'b1, 1, 32'h2000, 32'hFFFFFF80);
    start_load(1, 1'b0, 32'h2000);
    run_read("lbu", 1'b1, 1, 32'h2000, 32'h00000080);
    start_load(2, 1'b1, 32'h2010);
    run_read("lh", 1'b1, 2, 32'h2010, 32'hFFFFFFFE);
    start_load(2, 1'b0, 32'h2010);
    run_read("lhu", 1'b1, 2, 32'h2010, 32'h0000FFFE);
    start_load(4, 1'b1, 32'h2020);
    run_read("lw", 1'b1, 4, 32'h2020, 32'h44332211);

    // Store beats a fetch pulsed in the same cycle
    set_store(4, 32'h3000, 32'hDEADBEEF);
    in_fetcher_flag = 1'b1; in_fetcher_addr = 32'h0004;
    tick();
    in_rob_flag = 1'b0; in_fetcher_flag = 1'b0;
    check_wbyte("sw0", 32'h3000, 8'hEF);
    tick(); check_wbyte("sw1", 32'h3001, 8'hBE);
    tick(); check_wbyte("sw2", 32'h3002, 8'hAD);
    tick(); check_wbyte("sw3", 32'h3003, 8'hDE);
    tick();
    check_eq("sw_done_wr", mem_wr, 32'd0);
    check_eq("sw_done_flag", out_rob_flag, 32'd1);
    check_eq("sw_done_fflag", out_fetcher_flag, 32'd0);
    tick();
    check_eq("queued_fetch_a", mem_a, 32'h0004);
    check_eq("sw_flag_off", out_rob_flag, 32'd0);
    run_read("fetch2", 1'b0, 4, 32'h0004, 32'h00100093);

    // IO write stalled for three cycles
    set_store(1, 32'h30000, 32'h00000041);
    io_buffer_full = 1'b1;
    tick();
    in_rob_flag = 1'b0;
    check_eq("io_stall0", mem_wr, 32'd0);
    tick(); check_eq("io_stall1", mem_wr, 32'd0);
    tick(); check_eq("io_stall2", mem_wr, 32'd0);
    io_buffer_full = 1'b0;
    tick(); check_wbyte("io_w", 32'h30000, 8'h41);
    check_eq("io_w_flag", out_rob_flag, 32'd0);
    tick();
    check_eq("io_done_wr", mem_wr, 32'd0);
    check_eq("io_done_flag", out_rob_flag, 32'd1);

    // Last byte of the IO window stalls; first byte past it does not
    set_store(1, 32'h30007, 32'h00000043);
    io_buffer_full = 1'b1;
    tick();
    in_rob_flag = 1'b0;
    check_eq("io_last_stall", mem_wr, 32'd0);
    io_buffer_full = 1'b0;
    tick(); check_wbyte("io_last_w", 32'h30007, 8'h43);
    tick(); check_eq("io_last_done", out_rob_flag, 32'd1);
    set_store(1, 32'h30008, 32'h00000042);
    io_buffer_full = 1'b1;
    tick();
    in_rob_flag = 1'b0;
    check_wbyte("io_past_w", 32'h30008, 8'h42);
    tick(); check_eq("io_past_done", out_rob_flag, 32'd1);
    io_buffer_full = 1'b0;
    tick();

    // Flush aborts a word load; simultaneous fetch dropped; queued store completes
    start_load(4, 1'b0, 32'h2020);
    set_store(1, 32'h3100, 32'h0000005A);
    tick();
    in_rob_flag = 1'b0;
    tick(); tick();
    in_rob_xbp = 1'b1;
    in_fetcher_flag = 1'b1; in_fetcher_addr = 32'h1000;
    tick();
    in_rob_xbp = 1'b0; in_fetcher_flag = 1'b0;
    check_eq("xbp_lflag", out_lsb_flag, 32'd0);
    check_eq("xbp_wr", mem_wr, 32'd0);
    tick();
    check_wbyte("xbp_store", 32'h3100, 8'h5A);
    tick();
    check_eq("xbp_store_done", out_rob_flag, 32'd1);
    for (int k = 0; k < 7; k++) begin
      tick();
      check_eq("xbp_no_fetch", out_fetcher_flag, 32'd0);
      check_eq("xbp_no_lsb", out_lsb_flag, 32'd0);
      check_eq("xbp_a_hold", mem_a, 32'h3100);
    end

    // Flush on the completion edge suppresses the done pulse
    start_load(1, 1'b1, 32'h2000);
    tick();
    check_eq("xbp_edge_pre", out_lsb_flag, 32'd0);
    in_rob_xbp = 1'b1;
    tick();
    in_rob_xbp = 1'b0;
    check_eq("xbp_edge_flag", out_lsb_flag, 32'd0);
    tick();
    check_eq("xbp_edge_after", out_lsb_flag, 32'd0);

    // rdy low: a request pulse is not captured
    rdy = 1'b0;
    in_fetcher_flag = 1'b1; in_fetcher_addr = 32'h1000;
    tick();
    in_fetcher_flag = 1'b0;
    rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("rdy_no_fetch", out_fetcher_flag, 32'd0);
      check_eq("rdy_a_hold", mem_a, 32'h2000);
    end

    // Reset in the middle of a word store
    set_store(4, 32'h3200, 32'h11223344);
    tick();
    in_rob_flag = 1'b0;
    check_wbyte("rw0", 32'h3200, 8'h44);
    tick();
    check_wbyte("rw1", 32'h3201, 8'h33);
    rst = 1'b1;
    tick();
    check_eq("mrst_wr", mem_wr, 32'd0);
    check_eq("mrst_a", mem_a, 32'd0);
    check_eq("mrst_dout", mem_dout, 32'd0);
    check_eq("mrst_flags", {out_fetcher_flag, out_lsb_flag, out_rob_flag}, 32'd0);
    check_eq("mrst_fdata", out_fetcher_data, 32'd0);
    check_eq("mrst_ldata", out_lsb_data, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("mrst_idle_wr", mem_wr, 32'd0);
    check_eq("mrst_no_rob", out_rob_flag, 32'd0);
    start_fetch(32'h1000);
    run_read("fetch3", 1'b0, 4, 32'h1000, 32'h00100513);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
